// File: rtl/captura_operandos_alu_if.sv
// captura_operandos_alu_if: board I/O, ALU inputs and ALU results for the operand loader
interface captura_operandos_alu_if #(parameter int ANCHO = 4);
   logic [ANCHO-1:0] interruptores;
   logic             boton;
   logic [ANCHO-1:0] resultado_alu;
   logic [3:0]       banderas_alu;
   logic [ANCHO-1:0] operandoA;
   logic [ANCHO-1:0] operandoB;
   logic [3:0]       seleccion;
   logic             valido;
   logic [ANCHO-1:0] resultado;
   logic [3:0]       banderas;
   logic [2:0]       estado;
   modport master (
      output interruptores, boton, resultado_alu, banderas_alu,
      input  operandoA, operandoB, seleccion, valido, resultado, banderas, estado
   );
   modport slave (
      input  interruptores, boton, resultado_alu, banderas_alu,
      output operandoA, operandoB, seleccion, valido, resultado, banderas, estado
   );
endinterface

// File: rtl/captura_operandos_alu.sv
// captura_operandos_alu: debounced button loads A, B and opcode from switches, then latches the ALU result
module captura_operandos_alu #(
   parameter int ANCHO         = 4,
   parameter int REBOTE_CICLOS = 500000
) (
   input logic                   clk,
   input logic                   rst_n,
   captura_operandos_alu_if.slave bus
);
   localparam int CW = $clog2(REBOTE_CICLOS + 1);
   typedef enum logic [2:0] {
      CARGA_A  = 3'd0,
      CARGA_B  = 3'd1,
      CARGA_OP = 3'd2,
      EJECUTA  = 3'd3,
      MUESTRA  = 3'd4
   } estado_t;
   logic          sinc1, sinc2, limpio, limpio_d, pulso;
   logic [CW-1:0] cuenta;
   estado_t       st, st_n;
   logic          carga_a, carga_b, carga_op;
   // synchronise the button, accept a level only after it holds for REBOTE_CICLOS cycles, pulse on the rise
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sinc1    <= 1'b0;
         sinc2    <= 1'b0;
         limpio   <= 1'b0;
         limpio_d <= 1'b0;
         pulso    <= 1'b0;
         cuenta   <= '0;
      end else begin
         sinc1    <= bus.boton;
         sinc2    <= sinc1;
         limpio_d <= limpio;
         pulso    <= limpio & ~limpio_d;
         if (sinc2 != limpio) begin
            if (cuenta >= CW'(REBOTE_CICLOS - 1)) begin
               limpio <= sinc2;
               cuenta <= '0;
            end else begin
               cuenta <= cuenta + 1'b1;
            end
         end else begin
            cuenta <= '0;
         end
      end
   end
   // next state and load strobes; EJECUTA always moves on since no pulse can land there
   always_comb begin
      st_n     = st;
      carga_a  = 1'b0;
      carga_b  = 1'b0;
      carga_op = 1'b0;
      case (st)
         CARGA_A: begin
            carga_a = pulso;
            st_n    = pulso ? CARGA_B : CARGA_A;
         end
         CARGA_B: begin
            carga_b = pulso;
            st_n    = pulso ? CARGA_OP : CARGA_B;
         end
         CARGA_OP: begin
            carga_op = pulso;
            st_n     = pulso ? EJECUTA : CARGA_OP;
         end
         EJECUTA: st_n = MUESTRA;
         MUESTRA: st_n = pulso ? CARGA_A : MUESTRA;
         default: st_n = CARGA_A;
      endcase
   end
   // state register plus the held ALU inputs and the latched result/flags
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st            <= CARGA_A;
         bus.operandoA <= '0;
         bus.operandoB <= '0;
         bus.seleccion <= '0;
         bus.resultado <= '0;
         bus.banderas  <= '0;
      end else begin
         st <= st_n;
         if (carga_a) bus.operandoA <= bus.interruptores;
         if (carga_b) bus.operandoB <= bus.interruptores;
         if (carga_op) bus.seleccion <= bus.interruptores[3:0];
         if (st == EJECUTA) begin
            bus.resultado <= bus.resultado_alu;
            bus.banderas  <= bus.banderas_alu;
         end
      end
   end
   assign bus.valido = (st == EJECUTA);
   assign bus.estado = st;
endmodule

// File: tb/tb_captura_operandos_alu.sv
// tb_captura_operandos_alu: randomized loader sequences against a press-level model with a stand-in ALU
module tb_captura_operandos_alu;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   n_valido = 0;
   logic [3:0] flags_seen = '0;
   logic [4:0] alu_out;
   captura_operandos_alu_if #(.ANCHO(4)) bus ();
   captura_operandos_alu #(.ANCHO(4), .REBOTE_CICLOS(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );
   always #5 clk = ~clk;
   function automatic logic [4:0] alu_x(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
      case (op)
         4'h0:    return {1'b0, a} + {1'b0, b};
         4'h1:    return {1'b0, a} - {1'b0, b};
         4'h2:    return {1'b0, a & b};
         4'h3:    return {1'b0, a | b};
         4'h4:    return {1'b0, a ^ b};
         default: return {1'b0, ~a};
      endcase
   endfunction
   function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
      logic [4:0] x;
      x = alu_x(a, b, op);
      return {x[3:0] == 4'h0, x[4], x[3], ^x[3:0]};
   endfunction
   assign alu_out           = alu_x(bus.operandoA, bus.operandoB, bus.seleccion);
   assign bus.resultado_alu = alu_out[3:0];
   assign bus.banderas_alu  = alu_f(bus.operandoA, bus.operandoB, bus.seleccion);
   always @(posedge clk) begin
      if (bus.valido) begin
         n_valido   = n_valido + 1;
         flags_seen = bus.banderas_alu;
      end
   end
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic press(input logic [3:0] sw);
      bus.interruptores = sw;
      bus.boton = 1'b1;
      tick(12);
      bus.boton = 1'b0;
      tick(12);
   endtask
   task automatic do_reset();
      rst_n = 1'b0;
      bus.boton = 1'b0;
      tick(3);
      rst_n = 1'b1;
      tick(2);
   endtask
   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.boton = 1'b1;
      bus.interruptores = 4'($urandom);
      tick(3);
      total++;
      if ({bus.operandoA, bus.operandoB, bus.seleccion, bus.valido, bus.resultado, bus.banderas} !== 21'h0) begin
         bad++;
         $display("FAIL reset_outputs got=%h exp=0", {bus.operandoA, bus.operandoB, bus.seleccion, bus.valido, bus.resultado, bus.banderas});
      end
      total++;
      if (bus.estado !== 3'd0) begin
         bad++;
         $display("FAIL reset_estado got=%0d exp=0", bus.estado);
      end
      rst_n = 1'b1;
      bus.boton = 1'b0;
      tick(20);
      total++;
      if (bus.estado !== 3'd0) begin
         bad++;
         $display("FAIL reset_no_pulso got=%0d exp=0", bus.estado);
      end
   endtask
   task automatic test_sequence();
      int v0;
      do_reset();
      v0 = n_valido;
      press(4'h5);
      press(4'h3);
      press(4'h0);
      total++;
      if (n_valido - v0 != 1) begin
         bad++;
         $display("FAIL seq_valido got=%0d exp=1", n_valido - v0);
      end
      total++;
      if (bus.resultado !== 4'h8) begin
         bad++;
         $display("FAIL seq_resultado got=%h exp=8", bus.resultado);
      end
      total++;
      if (bus.estado !== 3'd4) begin
         bad++;
         $display("FAIL seq_estado got=%0d exp=4", bus.estado);
      end
      press(4'($urandom));
      total++;
      if ({bus.estado, bus.operandoA, bus.operandoB} !== {3'd0, 4'h5, 4'h3}) begin
         bad++;
         $display("FAIL seq_wrap got=%h exp=%h", {bus.estado, bus.operandoA, bus.operandoB}, {3'd0, 4'h5, 4'h3});
      end
   endtask
   task automatic test_bounce();
      logic [3:0] sw;
      do_reset();
      sw = 4'($urandom);
      bus.interruptores = sw;
      repeat (5) begin
         bus.boton = 1'b1;
         tick(2);
         bus.boton = 1'b0;
         tick(2);
      end
      total++;
      if (bus.estado !== 3'd0) begin
         bad++;
         $display("FAIL bounce_rejected got=%0d exp=0", bus.estado);
      end
      bus.boton = 1'b1;
      tick(20);
      bus.boton = 1'b0;
      tick(20);
      total++;
      if ({bus.estado, bus.operandoA} !== {3'd1, sw}) begin
         bad++;
         $display("FAIL bounce_one_pulso got=%h exp=%h", {bus.estado, bus.operandoA}, {3'd1, sw});
      end
   endtask
   task automatic test_long_hold();
      logic [3:0] sw;
      do_reset();
      sw = 4'($urandom);
      bus.interruptores = sw;
      bus.boton = 1'b1;
      tick(30);
      bus.interruptores = ~sw;
      tick(70);
      total++;
      if ({bus.estado, bus.operandoA} !== {3'd1, sw}) begin
         bad++;
         $display("FAIL hold_once got=%h exp=%h", {bus.estado, bus.operandoA}, {3'd1, sw});
      end
      bus.boton = 1'b0;
      tick(20);
      total++;
      if ({bus.estado, bus.operandoB} !== {3'd1, 4'h0}) begin
         bad++;
         $display("FAIL hold_release got=%h exp=%h", {bus.estado, bus.operandoB}, {3'd1, 4'h0});
      end
   endtask
   task automatic test_reset_mid();
      int v0;
      do_reset();
      press(4'h7);
      press(4'h2);
      total++;
      if ({bus.estado, bus.operandoA, bus.operandoB} !== {3'd2, 4'h7, 4'h2}) begin
         bad++;
         $display("FAIL mid_loaded got=%h exp=%h", {bus.estado, bus.operandoA, bus.operandoB}, {3'd2, 4'h7, 4'h2});
      end
      v0 = n_valido;
      rst_n = 1'b0;
      tick(1);
      total++;
      if ({bus.estado, bus.operandoA, bus.operandoB, bus.valido} !== 12'h0) begin
         bad++;
         $display("FAIL mid_reset got=%h exp=0", {bus.estado, bus.operandoA, bus.operandoB, bus.valido});
      end
      rst_n = 1'b1;
      tick(15);
      total++;
      if (n_valido != v0) begin
         bad++;
         $display("FAIL mid_no_valido got=%0d exp=%0d", n_valido, v0);
      end
   endtask
   task automatic test_sub_flags();
      do_reset();
      press(4'h2);
      press(4'h3);
      press(4'h1);
      total++;
      if (bus.resultado !== 4'hF) begin
         bad++;
         $display("FAIL sub_resultado got=%h exp=f", bus.resultado);
      end
      total++;
      if (bus.banderas !== flags_seen || bus.banderas !== 4'b0110) begin
         bad++;
         $display("FAIL sub_banderas got=%b exp=%b", bus.banderas, flags_seen);
      end
   endtask
   task automatic test_random();
      logic [3:0] a, b, op, r_exp, f_exp;
      int v0;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         a = 4'($urandom);
         b = 4'($urandom);
         op = 4'($urandom_range(0, 15));
         r_exp = alu_x(a, b, op) & 5'h0F;
         f_exp = alu_f(a, b, op);
         v0 = n_valido;
         press(a);
         press(b);
         press(op);
         total++;
         if ({bus.estado, bus.operandoA, bus.operandoB, bus.seleccion} !== {3'd4, a, b, op}) begin
            bad++;
            $display("FAIL rnd_inputs got=%h exp=%h", {bus.estado, bus.operandoA, bus.operandoB, bus.seleccion}, {3'd4, a, b, op});
         end
         total++;
         if ({bus.resultado, bus.banderas} !== {r_exp, f_exp} || n_valido - v0 != 1) begin
            bad++;
            $display("FAIL rnd_result got=%h/%0d exp=%h/1", {bus.resultado, bus.banderas}, n_valido - v0, {r_exp, f_exp});
         end
         press(4'($urandom));
         total++;
         if ({bus.estado, bus.resultado, bus.operandoA} !== {3'd0, r_exp, a}) begin
            bad++;
            $display("FAIL rnd_restart got=%h exp=%h", {bus.estado, bus.resultado, bus.operandoA}, {3'd0, r_exp, a});
         end
      end
   endtask
   initial begin
      bus.boton = 1'b0;
      bus.interruptores = '0;
      test_reset();
      test_sequence();
      test_bounce();
      test_long_hold();
      test_reset_mid();
      test_sub_flags();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
